filter_frame_sequencer: RTL and testbench
=========================================

Name: filter_frame_sequencer

Overview:
Streams one image frame from a source pixel RAM into the Filter block's i_rgb busy/vld input channel and writes the Filter's o_result output stream into a destination pixel RAM. Sits between the frame buffers and Filter in the accelerator top level. Generates the row-start flag (bit 24 of i_rgb_data), applies source-side backpressure through a small prefetch buffer, and reports frame completion.

Parameters:
IMG_W, 256, pixels per row (>=2)
IMG_H, 256, rows per frame (>=1)
ADDR_W, 16, RAM address width; must hold IMG_W*IMG_H-1

Ports:
i_clk  in  1  single clock, rising edge
i_rst  in  1  reset; asynchronous, active-low
i_start  in  1  one-cycle pulse; begins a frame when idle
o_busy  out  1  high from accepted start until o_done
o_done  out  1  one-cycle pulse when the last result has been written
o_src_addr  out  ADDR_W  source RAM read address
o_src_ren  out  1  source RAM read enable; data returns exactly 1 cycle later
i_src_rdata  in  24  source RAM read data {R,G,B}
o_rgb_vld  out  1  to Filter i_rgb_vld
o_rgb_data  out  25  to Filter i_rgb_data; [24]=row-start flag, [23:0]=pixel
i_rgb_busy  in  1  from Filter i_rgb_busy
i_result_vld  in  1  from Filter o_result_vld
i_result_data  in  24  from Filter o_result_data
o_result_busy  out  1  to Filter o_result_busy
o_dst_addr  out  ADDR_W  destination RAM write address
o_dst_wen  out  1  destination RAM write enable
o_dst_wdata  out  24  destination RAM write data

Behaviour:
- Reset (i_rst low, async): state IDLE. All counters 0, prefetch buffer empty. o_busy, o_done, o_src_ren, o_rgb_vld, o_dst_wen = 0. o_result_busy = 1. Address and data outputs = 0.
- Handshake: a transfer occurs on an edge where vld=1 and busy=0. o_rgb_vld and o_rgb_data are held stable until the transfer occurs.
- FSM states:
  - IDLE: i_start moves to RUN; o_busy rises on the next cycle.
  - RUN: while rd_cnt < N (N = IMG_W*IMG_H), issue reads.
  - DRAIN: entered after the last pixel is sent; waits for the remaining results.
  - DONE: one cycle; o_done=1; then returns to IDLE.
- i_start is ignored outside IDLE.
- Prefetch: 2-entry FIFO between source RAM and the Filter channel.
  - A read issues when occupancy plus reads in flight is below 2.
  - Reads are issued at sequential addresses 0..N-1.
  - Read data is pushed into the FIFO one cycle after o_src_ren.
  - The FIFO head drives o_rgb_data[23:0].
  - Full throughput is one pixel per cycle when i_rgb_busy stays 0.
- Row-start flag: o_rgb_data[24]=1 exactly when the sent pixel index is a multiple of IMG_W, i.e. pixels 0, IMG_W, 2*IMG_W, ...
- Results: o_result_busy=0 in RUN and DRAIN, 1 otherwise.
  - Each accepted result is written the same edge: o_dst_wen=1 (registered, visible the cycle after acceptance), o_dst_addr=rcv_cnt, o_dst_wdata=i_result_data.
  - rcv_cnt increments on each accepted result.
- Completion: DRAIN goes to DONE on the edge where rcv_cnt reaches N. Results arriving in IDLE are not accepted (busy=1).
- Results may be accepted before all pixels are sent. Simultaneous send and receive in one cycle are independent.
- Counters rd_cnt, snd_cnt, rcv_cnt are ADDR_W+1 bits and never wrap within a frame. They are cleared on leaving IDLE.
- An async reset mid-frame aborts immediately to the reset state. Pixels in flight are discarded and no o_done is produced.

Test Plan:
- IMG_W=4, IMG_H=2, Filter model with busy=0 and 3-cycle result latency, start pulse:
  - 8 pixels are sent in 8 consecutive cycles.
  - bit24 is set on pixels 0 and 4 only.
  - dst addresses 0..7 are written with the model outputs.
  - o_done pulses once; o_busy spans start to done.
- i_rgb_busy toggled pseudo-randomly:
  - o_rgb_data is held stable while stalled.
  - No pixel is dropped or duplicated (sequence 0..N-1 checked).
  - No more than 2 outstanding reads + buffered entries at any time.
- Result at the same edge as the last pixel send: rcv and snd both count correctly; done follows the 8th result.
- i_start pulsed again during RUN: ignored; exactly one frame is processed and one o_done.
- Reset asserted low at pixel 5 of 8: all outputs return to reset values asynchronously. A new start after release processes a full frame from address 0 with bit24 on pixel 0.
- IMG_W=1, IMG_H=3: every pixel carries bit24=1; 3 writes occur, then done.

Source files
------------

// File: rtl/filter_frame_sequencer.sv
// Streams one frame from the source pixel RAM into the Filter input channel and
// writes the Filter result stream into the destination pixel RAM.
module filter_frame_sequencer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_src_addr,
    output logic              o_src_ren,
    input  logic [23:0]       i_src_rdata,
    output logic              o_rgb_vld,
    output logic [24:0]       o_rgb_data,
    input  logic              i_rgb_busy,
    input  logic              i_result_vld,
    input  logic [23:0]       i_result_data,
    output logic              o_result_busy,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic              o_dst_wen,
    output logic [23:0]       o_dst_wdata
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] N        = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] N_M1     = CNT_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] snd_cnt;
    logic [CNT_W-1:0] rcv_cnt;
    logic [CNT_W-1:0] snd_col;
    logic [23:0]      fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             vld_p1;
    logic             active;
    logic             src_ren;
    logic             send;
    logic             accept;

    assign active        = (state == S_RUN) || (state == S_DRAIN);
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);
    assign o_result_busy = !active;
    assign o_rgb_vld     = (fifo_cnt != 2'd0);
    assign send          = o_rgb_vld && !i_rgb_busy;
    assign accept        = i_result_vld && active;

    // The pixel leaving this cycle frees a slot, which sustains one read per cycle.
    assign src_ren = (state == S_RUN) && (rd_cnt < N) &&
                     (({1'b0, fifo_cnt} + {2'b00, vld_p1}) < (3'd2 + {2'b00, send}));

    assign o_src_ren  = src_ren;
    assign o_src_addr = src_ren ? rd_cnt[ADDR_W-1:0] : '0;
    assign o_rgb_data = o_rgb_vld ? {(snd_col == '0), fifo_mem[rd_ptr]} : '0;

    // Stage p1: read data returned by the source RAM lands in the prefetch buffer
    always_ff @(posedge i_clk) begin
        if (vld_p1) begin
            fifo_mem[wr_ptr] <= i_src_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            rd_cnt      <= '0;
            snd_cnt     <= '0;
            rcv_cnt     <= '0;
            snd_col     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            vld_p1      <= 1'b0;
            o_dst_wen   <= 1'b0;
            o_dst_addr  <= '0;
            o_dst_wdata <= '0;
        end else begin
            vld_p1   <= src_ren;
            fifo_cnt <= fifo_cnt + 2'(vld_p1) - 2'(send);
            if (vld_p1) begin
                wr_ptr <= !wr_ptr;
            end
            if (send) begin
                rd_ptr  <= !rd_ptr;
                snd_cnt <= snd_cnt + 1'b1;
                snd_col <= (snd_col == LAST_COL) ? '0 : snd_col + 1'b1;
            end
            if (src_ren) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            // Stage p1: accepted result becomes a destination write
            o_dst_wen <= accept;
            if (accept) begin
                rcv_cnt     <= rcv_cnt + 1'b1;
                o_dst_addr  <= rcv_cnt[ADDR_W-1:0];
                o_dst_wdata <= i_result_data;
            end

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state   <= S_RUN;
                        rd_cnt  <= '0;
                        snd_cnt <= '0;
                        rcv_cnt <= '0;
                        snd_col <= '0;
                    end
                end
                S_RUN: begin
                    if (send && (snd_cnt == N_M1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((rcv_cnt == N) || (accept && (rcv_cnt == N_M1))) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Bench for filter_frame_sequencer: two frame geometries, a source RAM model, a
// latency-configurable Filter model and a destination RAM reference comparison.
module tb_filter_frame_sequencer;

    localparam int AW   = 8;
    localparam int MAXN = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          f_start     [2];
    logic          f_busy      [2];
    logic          f_done      [2];
    logic [AW-1:0] f_src_addr  [2];
    logic          f_src_ren   [2];
    logic [23:0]   f_src_rdata [2];
    logic          f_rgb_vld   [2];
    logic [24:0]   f_rgb_data  [2];
    logic          f_rgb_busy  [2];
    logic          f_res_vld   [2];
    logic [23:0]   f_res_data  [2];
    logic          f_res_busy  [2];
    logic [AW-1:0] f_dst_addr  [2];
    logic          f_dst_wen   [2];
    logic [23:0]   f_dst_wdata [2];

    filter_frame_sequencer #(.IMG_W(4), .IMG_H(2), .ADDR_W(AW)) dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_start(f_start[0]), .o_busy(f_busy[0]), .o_done(f_done[0]),
        .o_src_addr(f_src_addr[0]), .o_src_ren(f_src_ren[0]), .i_src_rdata(f_src_rdata[0]),
        .o_rgb_vld(f_rgb_vld[0]), .o_rgb_data(f_rgb_data[0]), .i_rgb_busy(f_rgb_busy[0]),
        .i_result_vld(f_res_vld[0]), .i_result_data(f_res_data[0]), .o_result_busy(f_res_busy[0]),
        .o_dst_addr(f_dst_addr[0]), .o_dst_wen(f_dst_wen[0]), .o_dst_wdata(f_dst_wdata[0])
    );

    filter_frame_sequencer #(.IMG_W(1), .IMG_H(3), .ADDR_W(AW)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_start(f_start[1]), .o_busy(f_busy[1]), .o_done(f_done[1]),
        .o_src_addr(f_src_addr[1]), .o_src_ren(f_src_ren[1]), .i_src_rdata(f_src_rdata[1]),
        .o_rgb_vld(f_rgb_vld[1]), .o_rgb_data(f_rgb_data[1]), .i_rgb_busy(f_rgb_busy[1]),
        .i_result_vld(f_res_vld[1]), .i_result_data(f_res_data[1]), .o_result_busy(f_res_busy[1]),
        .o_dst_addr(f_dst_addr[1]), .o_dst_wen(f_dst_wen[1]), .o_dst_wdata(f_dst_wdata[1])
    );

    int checks   = 0;
    int failures = 0;
    int img_w [2] = '{4, 1};
    int n_pix [2] = '{8, 3};
    int busy_pct  = 0;
    int lat       = 3;
    bit junk_vld  = 1'b0;
    int cycle     = 0;

    logic [23:0]   src_mem  [2][MAXN];
    logic [23:0]   dst_mem  [2][MAXN];
    logic [23:0]   fq_data  [2][MAXN];
    int            fq_due   [2][MAXN];
    int            fq_wr [2], fq_rd [2], rd_issued [2], sent [2], writes [2], dones [2], flags [2];
    int            first_snd, last_snd;
    bit            overlap_seen;
    bit            exp_busy   [2];
    bit            stall_prev [2];
    logic [24:0]   data_prev  [2];
    bit            rd_pend    [2];
    logic [AW-1:0] rd_addr_pend [2];

    // Stand-in for the Filter's arithmetic: any bijective pixel transform will do.
    function automatic logic [23:0] filt(input logic [23:0] p);
        return {p[7:0], p[23:8]} ^ 24'h5A3C96;
    endfunction

    task automatic new_frame(input int u);
        for (int k = 0; k < MAXN; k++) begin
            src_mem[u][k] = {16'($urandom), 8'(k)};
            dst_mem[u][k] = 'x;
        end
        fq_wr[u] = 0; fq_rd[u] = 0; rd_issued[u] = 0; sent[u] = 0;
        writes[u] = 0; dones[u] = 0; flags[u] = 0;
        stall_prev[u] = 1'b0; rd_pend[u] = 1'b0;
        overlap_seen = 1'b0; first_snd = -1; last_snd = -1;
    endtask

    // One clock cycle for instance u; entered and left just after a falling edge.
    task automatic tick(input int u, input bit start_req);
        bit snd, acc, exp_done, have_res, exp_rbusy;
        logic [24:0] exp_px;
        f_start[u]    = start_req;
        f_rgb_busy[u] = ($urandom_range(99) < busy_pct);
        have_res      = (fq_rd[u] < fq_wr[u]) && (fq_due[u][fq_rd[u]] <= cycle);
        f_res_vld[u]  = have_res || junk_vld;
        f_res_data[u] = have_res ? fq_data[u][fq_rd[u]] : 24'($urandom);
        #1;
        if (f_dst_wen[u] === 1'b1) begin
            if (int'(f_dst_addr[u]) < n_pix[u]) dst_mem[u][f_dst_addr[u]] = f_dst_wdata[u];
            writes[u]++;
        end
        exp_done = (f_dst_wen[u] === 1'b1) && (writes[u] == n_pix[u]);
        if (f_done[u] === 1'b1) dones[u]++;
        checks++;
        if (f_done[u] !== exp_done) begin
            $display("FAIL done u%0d cyc%0d: got %b want %b", u, cycle, f_done[u], exp_done);
            failures++;
        end
        checks++;
        if (f_busy[u] !== exp_busy[u]) begin
            $display("FAIL busy u%0d cyc%0d: got %b want %b", u, cycle, f_busy[u], exp_busy[u]);
            failures++;
        end
        exp_rbusy = !exp_busy[u] || exp_done;
        checks++;
        if (f_res_busy[u] !== exp_rbusy) begin
            $display("FAIL result_busy u%0d cyc%0d: got %b want %b", u, cycle, f_res_busy[u], exp_rbusy);
            failures++;
        end
        if (stall_prev[u]) begin
            checks++;
            if (f_rgb_vld[u] !== 1'b1 || f_rgb_data[u] !== data_prev[u]) begin
                $display("FAIL stall_hold u%0d cyc%0d: got %b/%h want 1/%h", u, cycle,
                         f_rgb_vld[u], f_rgb_data[u], data_prev[u]);
                failures++;
            end
        end
        if (f_rgb_vld[u] === 1'b1) begin
            checks++;
            if (sent[u] >= n_pix[u]) begin
                $display("FAIL extra_pixel u%0d cyc%0d: got %h want no pixel", u, cycle, f_rgb_data[u]);
                failures++;
            end else begin
                exp_px = {((sent[u] % img_w[u]) == 0), src_mem[u][sent[u]]};
                if (f_rgb_data[u] !== exp_px) begin
                    $display("FAIL pixel%0d u%0d: got %h want %h", sent[u], u, f_rgb_data[u], exp_px);
                    failures++;
                end
            end
        end
        snd = (f_rgb_vld[u] === 1'b1) && !f_rgb_busy[u];
        acc = f_res_vld[u] && (f_res_busy[u] === 1'b0);
        stall_prev[u] = (f_rgb_vld[u] === 1'b1) && f_rgb_busy[u];
        data_prev[u]  = f_rgb_data[u];
        if (snd) begin
            if (sent[u] == 0) first_snd = cycle;
            last_snd = cycle;
            if (f_rgb_data[u][24]) flags[u]++;
            if (fq_wr[u] < MAXN) begin
                fq_data[u][fq_wr[u]] = filt(f_rgb_data[u][23:0]);
                fq_due[u][fq_wr[u]]  = cycle + lat;
                fq_wr[u]++;
            end
            sent[u]++;
            if (sent[u] == n_pix[u] && acc) overlap_seen = 1'b1;
        end
        if (f_src_ren[u] === 1'b1) begin
            checks++;
            if (f_src_addr[u] !== AW'(rd_issued[u])) begin
                $display("FAIL src_addr u%0d cyc%0d: got %0d want %0d", u, cycle, f_src_addr[u], rd_issued[u]);
                failures++;
            end
            rd_issued[u]++;
            rd_addr_pend[u] = f_src_addr[u];
        end
        rd_pend[u] = (f_src_ren[u] === 1'b1);
        checks++;
        if (rd_issued[u] - sent[u] > 2 || rd_issued[u] > n_pix[u]) begin
            $display("FAIL outstanding u%0d cyc%0d: got reads=%0d sent=%0d want <=2 ahead, <=%0d total",
                     u, cycle, rd_issued[u], sent[u], n_pix[u]);
            failures++;
        end
        if (acc) begin
            checks++;
            if (!have_res) begin
                $display("FAIL result_accept u%0d cyc%0d: got accepted want refused", u, cycle);
                failures++;
            end else begin
                fq_rd[u]++;
            end
        end
        if (exp_done) exp_busy[u] = 1'b0;
        else if (start_req && !exp_busy[u]) exp_busy[u] = 1'b1;
        @(posedge clk);
        #1;
        if (rd_pend[u] && int'(rd_addr_pend[u]) < MAXN) f_src_rdata[u] = src_mem[u][rd_addr_pend[u]];
        cycle++;
        @(negedge clk);
    endtask

    task automatic run_frame(input int u, input int restart_at);
        int c;
        new_frame(u);
        tick(u, 1'b1);
        c = 0;
        while (dones[u] == 0 && c < 300) begin
            tick(u, c == restart_at);
            c++;
        end
        checks++;
        if (dones[u] == 0) begin
            $display("FAIL frame_timeout u%0d: got no done in %0d cycles want done", u, c);
            failures++;
        end
        repeat (3) tick(u, 1'b0);
        checks++;
        if (dones[u] != 1) begin
            $display("FAIL done_count u%0d: got %0d want 1", u, dones[u]);
            failures++;
        end
        checks++;
        if (sent[u] != n_pix[u] || writes[u] != n_pix[u]) begin
            $display("FAIL frame_counts u%0d: got sent=%0d writes=%0d want %0d", u, sent[u], writes[u], n_pix[u]);
            failures++;
        end
        for (int k = 0; k < n_pix[u]; k++) begin
            checks++;
            if (dst_mem[u][k] !== filt(src_mem[u][k])) begin
                $display("FAIL dst_word%0d u%0d: got %h want %h", k, u, dst_mem[u][k], filt(src_mem[u][k]));
                failures++;
            end
        end
    endtask

    task automatic test_reset();
        logic [70:0] got, want;
        rst_n = 1'b0;
        #1;
        want = '0;
        want[65] = 1'b1;
        for (int u = 0; u < 2; u++) begin
            got = {f_busy[u], f_done[u], f_src_ren[u], f_rgb_vld[u], f_dst_wen[u], f_res_busy[u],
                   f_src_addr[u], f_rgb_data[u], f_dst_addr[u], f_dst_wdata[u]};
            checks++;
            if (got !== want) begin
                $display("FAIL reset_outputs u%0d: got %h want %h", u, got, want);
                failures++;
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_results();
        new_frame(0);
        junk_vld = 1'b1;
        repeat (4) tick(0, 1'b0);
        junk_vld = 1'b0;
        tick(0, 1'b0);
        checks++;
        if (writes[0] != 0) begin
            $display("FAIL idle_results: got %0d writes want 0", writes[0]);
            failures++;
        end
    endtask

    task automatic test_basic();
        busy_pct = 0;
        lat = 3;
        run_frame(0, -1);
        checks++;
        if (last_snd - first_snd != 7) begin
            $display("FAIL back_to_back: got span %0d want 7", last_snd - first_snd);
            failures++;
        end
        checks++;
        if (flags[0] != 2) begin
            $display("FAIL row_flags: got %0d want 2", flags[0]);
            failures++;
        end
    endtask

    task automatic test_stall();
        busy_pct = 50;
        for (int i = 0; i < 3; i++) begin
            lat = $urandom_range(1, 4);
            run_frame(0, -1);
        end
        busy_pct = 0;
    endtask

    task automatic test_overlap();
        busy_pct = 0;
        lat = 1;
        run_frame(0, -1);
        checks++;
        if (!overlap_seen) begin
            $display("FAIL overlap: got no result on last send edge want one");
            failures++;
        end
    endtask

    task automatic test_restart();
        busy_pct = 0;
        lat = 2;
        run_frame(0, 4);
    endtask

    task automatic test_abort_reset();
        logic [70:0] got, want;
        int c;
        busy_pct = 0;
        lat = 3;
        new_frame(0);
        tick(0, 1'b1);
        c = 0;
        while (sent[0] < 5 && c < 50) begin
            tick(0, 1'b0);
            c++;
        end
        checks++;
        if (sent[0] != 5 || dones[0] != 0) begin
            $display("FAIL abort_setup: got sent=%0d done=%0d want 5/0", sent[0], dones[0]);
            failures++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        want = '0;
        want[65] = 1'b1;
        got = {f_busy[0], f_done[0], f_src_ren[0], f_rgb_vld[0], f_dst_wen[0], f_res_busy[0],
               f_src_addr[0], f_rgb_data[0], f_dst_addr[0], f_dst_wdata[0]};
        checks++;
        if (got !== want) begin
            $display("FAIL abort_outputs: got %h want %h", got, want);
            failures++;
        end
        exp_busy[0]  = 1'b0;
        f_res_vld[0] = 1'b0;
        f_start[0]   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, -1);
    endtask

    task automatic test_narrow();
        busy_pct = 30;
        lat = 2;
        run_frame(1, -1);
        checks++;
        if (flags[1] != 3) begin
            $display("FAIL narrow_flags: got %0d want 3", flags[1]);
            failures++;
        end
        busy_pct = 0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            f_start[u]     = 1'b0;
            f_rgb_busy[u]  = 1'b0;
            f_res_vld[u]   = 1'b0;
            f_res_data[u]  = '0;
            f_src_rdata[u] = '0;
            exp_busy[u]    = 1'b0;
        end
        test_reset();
        test_idle_results();
        test_basic();
        test_stall();
        test_overlap();
        test_restart();
        test_abort_reset();
        test_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
